// File: rtl/mini_alu_pipe.sv
// Three-stage (fetch/execute/writeback) MiniAlu core with WB->EX forwarding and one-slot branch squash.
// Optional multiplier for opcode 7 is enabled by defining MINI_ALU_MUL_EN.
module mini_alu_pipe #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned IP_W   = 16,
  parameter int unsigned LED_W  = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iEnable,
  output logic [IP_W-1:0]       oIP,
  input  logic [4+3*ADDR_W-1:0] iInstruction,
  output logic [LED_W-1:0]      oLed,
  input  logic [ADDR_W-1:0]     iDbgAddr,
  output logic [DATA_W-1:0]     oDbgData
);

  localparam int unsigned INSTR_W = 4 + 3 * ADDR_W;
  localparam int unsigned DEPTH   = 2 ** ADDR_W;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LED = 4'd1;
  localparam logic [3:0] OP_BLE = 4'd2;
  localparam logic [3:0] OP_STO = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_JMP = 4'd5;
  localparam logic [3:0] OP_SUB = 4'd6;
`ifdef MINI_ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd7;
`endif

  logic [DATA_W-1:0]  rRegFile [DEPTH];
  logic [INSTR_W-1:0] rExInstr;
  logic               rSquash;
  logic               rWbValid;
  logic [ADDR_W-1:0]  rWbAddr;
  logic [DATA_W-1:0]  rWbData;

  logic [3:0]         exOp;
  logic [ADDR_W-1:0]  exDst;
  logic [ADDR_W-1:0]  exSrc1;
  logic [ADDR_W-1:0]  exSrc0;
  logic [DATA_W-1:0]  op1;
  logic [DATA_W-1:0]  op0;
  logic [DATA_W-1:0]  exRes;
  logic               exWrite;
  logic               exLed;
  logic               redirect;
  logic [IP_W-1:0]    target;

  // The fetched word is always latched; the registered squash flag turns it into
  // a NOP here, which is equivalent to loading a NOP into EX on the redirect edge.
  assign exOp   = rSquash ? OP_NOP : rExInstr[INSTR_W-1 -: 4];
  assign exDst  = rExInstr[3*ADDR_W-1 -: ADDR_W];
  assign exSrc1 = rExInstr[2*ADDR_W-1 -: ADDR_W];
  assign exSrc0 = rExInstr[ADDR_W-1:0];
  assign target = IP_W'(exDst);

  always_comb begin
    op1 = (rWbValid && (rWbAddr == exSrc1)) ? rWbData : rRegFile[exSrc1];
    op0 = (rWbValid && (rWbAddr == exSrc0)) ? rWbData : rRegFile[exSrc0];
  end

  always_comb begin
    exRes    = '0;
    exWrite  = 1'b0;
    exLed    = 1'b0;
    redirect = 1'b0;
    case (exOp)
      OP_LED: exLed = 1'b1;
      OP_BLE: redirect = (op1 <= op0);
      OP_STO: begin
        exWrite = 1'b1;
        exRes   = DATA_W'({exSrc1, exSrc0});
      end
      OP_ADD: begin
        exWrite = 1'b1;
        exRes   = op1 + op0;
      end
      OP_JMP: redirect = 1'b1;
      OP_SUB: begin
        exWrite = 1'b1;
        exRes   = op1 - op0;
      end
`ifdef MINI_ALU_MUL_EN
      OP_MUL: begin
        exWrite = 1'b1;
        exRes   = op1 * op0;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      oIP      <= '0;
      oLed     <= '0;
      rExInstr <= '0;
      rSquash  <= 1'b0;
      rWbValid <= 1'b0;
      rWbAddr  <= '0;
      rWbData  <= '0;
    end else if (iEnable) begin
      oIP      <= redirect ? target : oIP + IP_W'(1);
      rExInstr <= iInstruction;
      rSquash  <= redirect;
      rWbValid <= exWrite;
      rWbAddr  <= exDst;
      rWbData  <= exRes;
      if (exLed) begin
        oLed <= op1[LED_W-1:0];
      end
    end
  end

  // Register file is deliberately not reset; reset only clears the pending write.
  always_ff @(posedge Clock) begin
    if (iEnable && rWbValid) begin
      rRegFile[rWbAddr] <= rWbData;
    end
  end

  assign oDbgData = rRegFile[iDbgAddr];

endmodule

// File: tb/tb_mini_alu_pipe.sv
// Bench for mini_alu_pipe: random programs checked cycle by cycle against an
// instruction-level model, plus directed programs with hand-computed expectations.
module tb_mini_alu_pipe;

  localparam int unsigned MAXS = 400;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        iEnable;
  logic [15:0] oIP;
  logic [27:0] iInstruction;
  logic [7:0]  oLed;
  logic [7:0]  iDbgAddr;
  logic [15:0] oDbgData;

  logic [27:0] rom [256];
  int unsigned slotCnt;
  int          errors = 0;
  int          checks = 0;
  bit          modelOn = 1'b0;
  bit          randEn = 1'b0;
  bit          sawIP [256];

  // Model trace: fetch address per slot, and architectural state after N slots.
  logic [15:0] expIP [MAXS+1];
  logic [7:0]  stLed [MAXS+2];
  bit          stLedKnown [MAXS+2];
  logic [15:0] stReg [MAXS+2][8];
  logic [7:0]  stKnown [MAXS+2];

  mini_alu_pipe #(.DATA_W(16), .ADDR_W(8), .IP_W(16), .LED_W(8)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .iEnable(iEnable),
    .oIP(oIP),
    .iInstruction(iInstruction),
    .oLed(oLed),
    .iDbgAddr(iDbgAddr),
    .oDbgData(oDbgData)
  );

  always #5 Clock = ~Clock;

  assign iInstruction = rom[oIP[7:0]];

  always @(posedge Clock or posedge Reset) begin
    if (Reset) slotCnt <= 0;
    else if (iEnable) slotCnt <= slotCnt + 1;
  end

  function automatic logic [27:0] enc(int op, int dst, int s1, int s0);
    return {4'(op), 8'(dst), 8'(s1), 8'(s0)};
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (slot %0d, t=%0t)", name, got, exp, slotCnt, $time);
    end
  endtask

  // Sequential ISA interpreter; a taken branch costs one annulled fetch of pc+1.
  task automatic buildModel();
    logic [15:0] pc, tgt, a, b, r;
    logic [15:0] regs [8];
    logic [7:0]  known, led;
    bit          ledKnown, squashNext, taken, wr, ka, kb;
    logic [27:0] ins;
    logic [3:0]  op;
    logic [7:0]  dst, s1, s0;
    pc = '0; tgt = '0; known = '0; led = '0; ledKnown = 1'b1; squashNext = 1'b0;
    for (int i = 0; i < 8; i++) regs[i] = '0;
    stLed[0] = led; stLedKnown[0] = ledKnown; stReg[0] = regs; stKnown[0] = known;
    for (int k = 0; k <= int'(MAXS); k++) begin
      expIP[k] = pc;
      if (squashNext) begin
        squashNext = 1'b0;
        pc = tgt;
      end else begin
        ins = rom[pc[7:0]];
        op = ins[27:24]; dst = ins[23:16]; s1 = ins[15:8]; s0 = ins[7:0];
        a = regs[s1[2:0]]; ka = known[s1[2:0]];
        b = regs[s0[2:0]]; kb = known[s0[2:0]];
        taken = 1'b0; wr = 1'b0; r = '0;
        case (op)
          4'd1: begin led = a[7:0]; ledKnown = ka; end
          4'd2: taken = (a <= b);
          4'd3: begin r = {s1, s0}; wr = 1'b1; ka = 1'b1; kb = 1'b1; end
          4'd4: begin r = a + b; wr = 1'b1; end
          4'd5: taken = 1'b1;
          4'd6: begin r = a - b; wr = 1'b1; end
`ifdef MINI_ALU_MUL_EN
          4'd7: begin r = a * b; wr = 1'b1; end
`endif
          default: ;
        endcase
        if (wr) begin
          regs[dst[2:0]] = r;
          known[dst[2:0]] = ka & kb;
        end
        pc = pc + 16'd1;
        if (taken) begin
          squashNext = 1'b1;
          tgt = {8'h00, dst};
        end
      end
      stLed[k+1] = led; stLedKnown[k+1] = ledKnown; stReg[k+1] = regs; stKnown[k+1] = known;
    end
  endtask

  task automatic compareCycle();
    int unsigned c, jl, jr;
    c = slotCnt;
    if (c > MAXS) return;
    jl = (c >= 1) ? c - 1 : 0;
    jr = (c >= 2) ? c - 2 : 0;
    check("oIP", {16'h0, oIP}, {16'h0, expIP[c]});
    if (stLedKnown[jl]) check("oLed", {24'h0, oLed}, {24'h0, stLed[jl]});
    if (stKnown[jr][iDbgAddr[2:0]]) check("dbgReg", {16'h0, oDbgData}, {16'h0, stReg[jr][iDbgAddr[2:0]]});
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    iEnable = randEn ? ($urandom_range(0, 9) < 8) : 1'b1;
    iDbgAddr = 8'($urandom_range(0, 7));
    @(negedge Clock);
    sawIP[oIP[7:0]] = 1'b1;
    if (modelOn && !Reset) compareCycle();
  endtask

  task automatic genRandomProgram();
    int op;
    for (int i = 0; i < 8; i++) rom[i] = enc(3, i, $urandom_range(0, 255), $urandom_range(0, 255));
    for (int i = 8; i < 256; i++) begin
      op = $urandom_range(0, 15);
      case (op)
        2, 5:       rom[i] = enc(op, $urandom_range(8, 255), $urandom_range(0, 7), $urandom_range(0, 7));
        3:          rom[i] = enc(op, $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255));
        1, 4, 6, 7: rom[i] = enc(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
        default:    rom[i] = enc(op, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      endcase
    end
  endtask

  task automatic runUntil(int unsigned slot, string name);
    for (int n = 0; n < 200 && slotCnt != slot; n++) tick();
    check(name, slotCnt, slot);
  endtask

  task automatic peekReg(string name, int addr, logic [15:0] exp);
    iDbgAddr = 8'(addr);
    #1;
    check(name, {16'h0, oDbgData}, {16'h0, exp});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    iEnable = 1'b0;
    iDbgAddr = '0;
    for (int i = 0; i < 256; i++) begin rom[i] = '0; sawIP[i] = 1'b0; end
    #2;
    check("resetIP", {16'h0, oIP}, 32'h0);
    check("resetLed", {24'h0, oLed}, 32'h0);

    // Random programs with random stalls
    for (int p = 0; p < 4; p++) begin
      Reset = 1'b1;
      genRandomProgram();
      buildModel();
      tick(); tick();
      Reset = 1'b0;
      modelOn = 1'b1; randEn = 1'b1;
      repeat (300) tick();
      modelOn = 1'b0; randEn = 1'b0;
    end

    // Reset mid-run with a write pending in WB
    Reset = 1'b1;
    for (int i = 0; i < 256; i++) rom[i] = '0;
    rom[0] = enc(3, 6, 8'hAB, 8'hCD);
    rom[1] = enc(1, 0, 6, 0);
    rom[2] = enc(3, 6, 8'h11, 8'h11);
    rom[3] = enc(3, 6, 8'h22, 8'h22);
    rom[4] = enc(5, 4, 0, 0);
    tick(); tick();
    Reset = 1'b0;
    runUntil(4, "rstReachSlot");
    check("preRstLed", {24'h0, oLed}, 32'hCD);
    Reset = 1'b1;
    #1;
    check("rstIP", {16'h0, oIP}, 32'h0);
    check("rstLed", {24'h0, oLed}, 32'h0);
    for (int i = 0; i < 256; i++) rom[i] = enc(5, 0, 0, 0);
    tick(); tick();
    Reset = 1'b0;
    check("restartIP", {16'h0, oIP}, 32'h0);
    repeat (10) tick();
    peekReg("rstNoStray", 6, 16'hABCD);
    check("rstLedHeld", {24'h0, oLed}, 32'h0);

    // Directed program: forwarding, wrap, jump/branch squash, multiply
    Reset = 1'b1;
    for (int i = 0; i < 256; i++) rom[i] = '0;
    rom[8'h00] = enc(3, 1, 8'h00, 8'h05);
    rom[8'h01] = enc(3, 2, 8'h00, 8'h03);
    rom[8'h02] = enc(4, 3, 2, 1);
    rom[8'h03] = enc(1, 0, 3, 0);
    rom[8'h04] = enc(5, 8'h10, 0, 0);
    rom[8'h05] = enc(3, 3, 8'h77, 8'h77);
    rom[8'h10] = enc(3, 1, 8'h00, 8'h00);
    rom[8'h11] = enc(3, 2, 8'h00, 8'h01);
    rom[8'h12] = enc(6, 3, 1, 2);
    rom[8'h13] = enc(3, 4, 8'h00, 8'h03);
    rom[8'h14] = enc(3, 6, 8'h00, 8'h03);
    rom[8'h15] = enc(2, 8'h20, 4, 6);
    rom[8'h16] = enc(3, 3, 8'h55, 8'h55);
    rom[8'h20] = enc(3, 4, 8'h00, 8'h04);
    rom[8'h21] = enc(2, 8'h30, 4, 6);
    rom[8'h22] = enc(3, 0, 8'h12, 8'h34);
    rom[8'h23] = enc(3, 1, 8'h01, 8'h00);
    rom[8'h24] = enc(3, 2, 8'h01, 8'h00);
    rom[8'h25] = enc(7, 0, 1, 2);
    rom[8'h27] = enc(5, 8'h27, 0, 0);
    buildModel();
    check("modelJmpTarget", {16'h0, expIP[6]}, 32'h10);
    check("modelSubWrap", {16'h0, stReg[12][3]}, 32'hFFFF);
    tick(); tick();
    for (int i = 0; i < 256; i++) sawIP[i] = 1'b0;
    Reset = 1'b0;
    modelOn = 1'b1;
    runUntil(9, "dirReachSlot9");
    peekReg("addFwd_r3", 3, 16'h0008);
    runUntil(40, "dirReachSlot40");
    modelOn = 1'b0;
    check("ledAdd", {24'h0, oLed}, 32'h08);
    peekReg("subWrap_r3", 3, 16'hFFFF);
    peekReg("bleNotTaken_r4", 4, 16'h0004);
    peekReg("sto_r1", 1, 16'h0100);
`ifdef MINI_ALU_MUL_EN
    peekReg("mul_r0", 0, 16'h0000);
`else
    peekReg("mulNop_r0", 0, 16'h1234);
`endif
    check("fetch05", 32'(sawIP[8'h05]), 32'd1);
    check("noFetch06", 32'(sawIP[8'h06]), 32'd0);
    check("fetch10", 32'(sawIP[8'h10]), 32'd1);
    check("fetch16", 32'(sawIP[8'h16]), 32'd1);
    check("noFetch17", 32'(sawIP[8'h17]), 32'd0);
    check("fetch22", 32'(sawIP[8'h22]), 32'd1);
    check("noFetch30", 32'(sawIP[8'h30]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
